// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive controller: input conditioning, start/data/parity/stop FSM, timeout and E0/F0 folding.
// Define PS2_ERR_CNT_EN to add a saturating frame error counter on err_cnt_o.
module ps2_rx_ctrl #(
   parameter int FILT_LEN    = 4,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        kclk_i,
   input  logic        kdata_i,
   output logic [7:0]  scan_code_o,
   output logic        scan_valid_o,
   output logic        break_o,
   output logic        ext_o,
   output logic [15:0] keycode_o,
   output logic        frame_err_o,
   output logic        busy_o,
   output logic [7:0]  err_cnt_o
);

   localparam int FW = $clog2(FILT_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP,
      DONE,
      ERR
   } state_t;

   state_t        state;
   logic          kclk_s1, kclk_s2;
   logic          kdata_s1, kdata_s2;
   logic          kclk_f, kclk_f_d;
   logic [FW-1:0] filt_cnt;
   logic          fall;
   logic [7:0]    shreg;
   logic [2:0]    bit_cnt;
   logic          parity;
   logic          ext_pend, brk_pend;
   logic [TW-1:0] to_cnt;
   logic          in_frame;
   logic          to_hit;

   // Synchronisers and kclk glitch filter: level changes only after FILT_LEN agreeing samples
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         kclk_s1  <= 1'b1;
         kclk_s2  <= 1'b1;
         kdata_s1 <= 1'b1;
         kdata_s2 <= 1'b1;
         kclk_f   <= 1'b1;
         kclk_f_d <= 1'b1;
         filt_cnt <= '0;
      end else begin
         kclk_s1  <= kclk_i;
         kclk_s2  <= kclk_s1;
         kdata_s1 <= kdata_i;
         kdata_s2 <= kdata_s1;
         kclk_f_d <= kclk_f;
         if (kclk_s2 == kclk_f) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
            kclk_f   <= kclk_s2;
            filt_cnt <= '0;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall     = kclk_f_d & ~kclk_f;
   assign in_frame = (state == DATA) || (state == PARITY) || (state == STOP);
   // A fall in the expiry cycle wins over the timeout
   assign to_hit   = in_frame && (to_cnt == TW'(TIMEOUT_CYC - 1)) && !fall;

   // Frame FSM; outputs are registered on the transition into DONE/ERR so they show in that cycle
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state        <= IDLE;
         busy_o       <= 1'b0;
         shreg        <= '0;
         bit_cnt      <= '0;
         parity       <= 1'b0;
         ext_pend     <= 1'b0;
         brk_pend     <= 1'b0;
         to_cnt       <= '0;
         scan_code_o  <= '0;
         scan_valid_o <= 1'b0;
         break_o      <= 1'b0;
         ext_o        <= 1'b0;
         keycode_o    <= '0;
         frame_err_o  <= 1'b0;
      end else begin
         scan_valid_o <= 1'b0;
         frame_err_o  <= 1'b0;

         if (in_frame && !fall) begin
            to_cnt <= to_cnt + 1'b1;
         end else begin
            to_cnt <= '0;
         end

         if (to_hit) begin
            state       <= ERR;
            frame_err_o <= 1'b1;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (fall && !kdata_s2) begin
                     state   <= DATA;
                     busy_o  <= 1'b1;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  if (fall) begin
                     shreg   <= {kdata_s2, shreg[7:1]};
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == 3'd7) begin
                        state <= PARITY;
                     end
                  end
               end
               PARITY: begin
                  if (fall) begin
                     parity <= kdata_s2;
                     state  <= STOP;
                  end
               end
               STOP: begin
                  if (fall) begin
                     if ((^shreg ^ parity) && kdata_s2) begin
                        state     <= DONE;
                        keycode_o <= {keycode_o[7:0], shreg};
                        if (shreg == 8'hE0) begin
                           ext_pend <= 1'b1;
                        end else if (shreg == 8'hF0) begin
                           brk_pend <= 1'b1;
                        end else begin
                           scan_valid_o <= 1'b1;
                           scan_code_o  <= shreg;
                           break_o      <= brk_pend;
                           ext_o        <= ext_pend;
                           ext_pend     <= 1'b0;
                           brk_pend     <= 1'b0;
                        end
                     end else begin
                        state       <= ERR;
                        frame_err_o <= 1'b1;
                        ext_pend    <= 1'b0;
                        brk_pend    <= 1'b0;
                     end
                  end
               end
               DONE, ERR: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
               default: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

`ifdef PS2_ERR_CNT_EN
   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         err_cnt_o <= '0;
      end else if (frame_err_o && (err_cnt_o != 8'hFF)) begin
         err_cnt_o <= err_cnt_o + 1'b1;
      end
   end
`else
   assign err_cnt_o = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Self-checking bench for ps2_rx_ctrl: directed scenarios plus randomized frames against a byte-level model.
module tb_ps2_rx_ctrl;

   logic        clk;
   logic        rstn;
   logic        kclk;
   logic        kdata;
   logic [7:0]  scan_code_o;
   logic        scan_valid_o;
   logic        break_o;
   logic        ext_o;
   logic [15:0] keycode_o;
   logic        frame_err_o;
   logic        busy_o;
   logic [7:0]  err_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;

   int n_vld = 0;
   int n_err = 0;
   int cyc = 0;
   int err_cyc = 0;
   int last_fall_cyc = 0;

   // reference model state
   logic [15:0] m_key;
   logic [7:0]  m_code;
   logic        m_brk, m_ext, m_brk_o, m_ext_o;
   bit          exp_vld, exp_err;
   int          m_errcnt;

   ps2_rx_ctrl #(
      .FILT_LEN    (4),
      .TIMEOUT_CYC (1000)
   ) dut (
      .clk_i        (clk),
      .rstn_i       (rstn),
      .kclk_i       (kclk),
      .kdata_i      (kdata),
      .scan_code_o  (scan_code_o),
      .scan_valid_o (scan_valid_o),
      .break_o      (break_o),
      .ext_o        (ext_o),
      .keycode_o    (keycode_o),
      .frame_err_o  (frame_err_o),
      .busy_o       (busy_o),
      .err_cnt_o    (err_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (scan_valid_o === 1'b1) n_vld <= n_vld + 1;
      if (frame_err_o === 1'b1) begin
         n_err   <= n_err + 1;
         err_cyc <= cyc;
      end
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      m_key = '0; m_code = '0; m_brk = 0; m_ext = 0; m_brk_o = 0; m_ext_o = 0;
      exp_vld = 0; exp_err = 0; m_errcnt = 0;
   endtask

   task automatic model_error();
      m_brk = 0; m_ext = 0; exp_err = 1; exp_vld = 0;
      if (m_errcnt != 255) m_errcnt++;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit good);
      exp_vld = 0; exp_err = 0;
      if (!good) begin
         model_error();
      end else begin
         m_key = {m_key[7:0], b};
         case (b)
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            default: begin
               exp_vld = 1; m_code = b; m_brk_o = m_brk; m_ext_o = m_ext;
               m_brk = 0; m_ext = 0;
            end
         endcase
      end
   endtask

   // Drives the first nbits of a frame (start, 8 data LSB first, odd parity, stop)
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input int nbits);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         kdata = bits[i];
         wait_cyc(50);
         kclk = 1'b0;
         last_fall_cyc = cyc;
         wait_cyc(100);
         kclk = 1'b1;
         wait_cyc(50);
      end
      kdata = 1'b1;
   endtask

   task automatic do_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
      n_vld = 0; n_err = 0;
      send_frame(b, bad_par, bad_stop, 11);
      wait_cyc(20);
      model_frame(b, !(bad_par || bad_stop));
   endtask

   task automatic test_reset();
      rstn = 1'b0; kclk = 1'b1; kdata = 1'b1;
      wait_cyc(5);
      model_reset();
      n_checks++;
      if (keycode_o !== 16'h0000) $display("FAIL reset_keycode: got %h expected 0000", keycode_o);
      else n_pass++;
      n_checks++;
      if (scan_code_o !== 8'h00) $display("FAIL reset_scan_code: got %h expected 00", scan_code_o);
      else n_pass++;
      n_checks++;
      if ({scan_valid_o, frame_err_o, busy_o, break_o, ext_o} !== 5'b0)
         $display("FAIL reset_flags: got %b expected 00000", {scan_valid_o, frame_err_o, busy_o, break_o, ext_o});
      else n_pass++;
      n_checks++;
      if (err_cnt_o !== 8'h00) $display("FAIL reset_err_cnt: got %h expected 00", err_cnt_o);
      else n_pass++;
      rstn = 1'b1;
      wait_cyc(10);
   endtask

   task automatic test_make();
      do_frame(8'h1C, 0, 0);
      n_checks++;
      if (n_vld !== 1) $display("FAIL make_pulses: got %0d expected 1", n_vld);
      else n_pass++;
      n_checks++;
      if ({scan_code_o, break_o, ext_o} !== {8'h1C, 1'b0, 1'b0})
         $display("FAIL make_code: got %h/%b/%b expected 1c/0/0", scan_code_o, break_o, ext_o);
      else n_pass++;
      n_checks++;
      if (keycode_o[7:0] !== 8'h1C) $display("FAIL make_keycode: got %h expected xx1c", keycode_o);
      else n_pass++;
   endtask

   task automatic test_break();
      do_frame(8'hF0, 0, 0);
      n_checks++;
      if (n_vld !== 0) $display("FAIL break_prefix_pulse: got %0d expected 0", n_vld);
      else n_pass++;
      do_frame(8'h1C, 0, 0);
      n_checks++;
      if ({n_vld == 1, scan_code_o, break_o, ext_o} !== {1'b1, 8'h1C, 1'b1, 1'b0})
         $display("FAIL break_code: got vld=%0d %h/%b/%b expected 1 1c/1/0", n_vld, scan_code_o, break_o, ext_o);
      else n_pass++;
      n_checks++;
      if (keycode_o !== 16'hF01C) $display("FAIL break_keycode: got %h expected f01c", keycode_o);
      else n_pass++;
      do_frame(8'h1C, 0, 0);
      n_checks++;
      if ({n_vld == 1, break_o} !== 2'b10)
         $display("FAIL break_cleared: got vld=%0d brk=%b expected 1 0", n_vld, break_o);
      else n_pass++;
   endtask

   task automatic test_ext();
      do_frame(8'hE0, 0, 0);
      do_frame(8'h75, 0, 0);
      n_checks++;
      if ({n_vld == 1, scan_code_o, ext_o, break_o} !== {1'b1, 8'h75, 1'b1, 1'b0})
         $display("FAIL ext_code: got vld=%0d %h/e%b/b%b expected 1 75/1/0", n_vld, scan_code_o, ext_o, break_o);
      else n_pass++;
      n_checks++;
      if (keycode_o !== 16'hE075) $display("FAIL ext_keycode: got %h expected e075", keycode_o);
      else n_pass++;
   endtask

   task automatic test_parity();
      do_frame(8'h1C, 1, 0);
      n_checks++;
      if ({n_err, n_vld} !== {32'd1, 32'd0})
         $display("FAIL parity_err: got err=%0d vld=%0d expected 1 0", n_err, n_vld);
      else n_pass++;
      n_checks++;
      if (keycode_o !== 16'hE075) $display("FAIL parity_keycode: got %h expected e075", keycode_o);
      else n_pass++;
`ifndef PS2_ERR_CNT_EN
      n_checks++;
      if (err_cnt_o !== 8'h00) $display("FAIL err_cnt_tied: got %h expected 00", err_cnt_o);
      else n_pass++;
`endif
      do_frame(8'h1C, 0, 0);
      n_checks++;
      if ({n_vld == 1, n_err == 0, scan_code_o, keycode_o} !== {2'b11, 8'h1C, 16'h751C})
         $display("FAIL parity_recover: got vld=%0d err=%0d %h %h expected 1 0 1c 751c", n_vld, n_err, scan_code_o, keycode_o);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int d;
      logic [15:0] key_before;
      key_before = keycode_o;
      n_vld = 0; n_err = 0;
      send_frame(8'hA5, 0, 0, 5);
      n_checks++;
      if (busy_o !== 1'b1) $display("FAIL timeout_busy_mid: got %b expected 1", busy_o);
      else n_pass++;
      for (int i = 0; i < 2000 && n_err == 0; i++) @(negedge clk);
      n_checks++;
      if (n_err != 1) begin
         $display("FAIL timeout_seen: got %0d errors expected 1", n_err);
      end else begin
         n_pass++;
         d = err_cyc - last_fall_cyc;
         n_checks++;
         if (d < 1000 || d > 1015) $display("FAIL timeout_latency: got %0d cycles expected 1000..1015", d);
         else n_pass++;
      end
      wait_cyc(3);
      n_checks++;
      if ({busy_o, n_vld == 0, keycode_o} !== {1'b0, 1'b1, key_before})
         $display("FAIL timeout_after: got busy=%b vld=%0d key=%h expected 0 0 %h", busy_o, n_vld, keycode_o, key_before);
      else n_pass++;
      model_error();
      do_frame(8'h29, 0, 0);
      n_checks++;
      if ({n_vld == 1, scan_code_o} !== {1'b1, 8'h29})
         $display("FAIL timeout_recover: got vld=%0d %h expected 1 29", n_vld, scan_code_o);
      else n_pass++;
   endtask

   task automatic test_glitch();
      n_vld = 0; n_err = 0;
      kdata = 1'b0;
      kclk = 1'b0;
      wait_cyc(2);
      kclk = 1'b1;
      wait_cyc(4);
      kdata = 1'b1;
      wait_cyc(50);
      n_checks++;
      if ({busy_o, n_err == 0, n_vld == 0} !== 3'b011)
         $display("FAIL glitch_ignored: got busy=%b err=%0d vld=%0d expected 0 0 0", busy_o, n_err, n_vld);
      else n_pass++;
   endtask

   task automatic test_mid_reset();
      do_frame(8'hF0, 0, 0);
      send_frame(8'h3A, 0, 0, 6);
      rstn = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({scan_code_o, keycode_o, scan_valid_o, frame_err_o, busy_o, break_o, ext_o, err_cnt_o} !== 37'b0)
         $display("FAIL midreset_outputs: got code=%h key=%h flags=%b cnt=%h expected all 0",
                  scan_code_o, keycode_o, {scan_valid_o, frame_err_o, busy_o, break_o, ext_o}, err_cnt_o);
      else n_pass++;
      rstn = 1'b1;
      model_reset();
      wait_cyc(10);
      do_frame(8'h1C, 0, 0);
      n_checks++;
      if ({n_vld == 1, n_err == 0, scan_code_o, break_o, keycode_o} !== {2'b11, 8'h1C, 1'b0, 16'h001C})
         $display("FAIL midreset_recover: got vld=%0d err=%0d %h b%b %h expected 1 0 1c 0 001c",
                  n_vld, n_err, scan_code_o, break_o, keycode_o);
      else n_pass++;
   endtask

`ifdef PS2_ERR_CNT_EN
   task automatic test_err_cnt();
      test_reset();
      for (int i = 0; i < 3; i++) do_frame(8'h5A, 1, 0);
      n_checks++;
      if (err_cnt_o !== 8'd3) $display("FAIL err_cnt: got %0d expected 3", err_cnt_o);
      else n_pass++;
   endtask
`endif

   task automatic test_random();
      logic [7:0] b;
      int r;
      bit bad, bad_stop;
      for (int k = 0; k < 10; k++) begin
         r = $urandom_range(0, 9);
         if (r < 2) b = 8'hE0;
         else if (r < 4) b = 8'hF0;
         else begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'hE0 || b == 8'hF0) b = b ^ 8'h01;
         end
         bad = ($urandom_range(0, 4) == 0);
         bad_stop = bad && ($urandom_range(0, 1) == 1);
         do_frame(b, bad && !bad_stop, bad_stop);
         n_checks++;
         if (n_vld != int'(exp_vld) || n_err != int'(exp_err))
            $display("FAIL rand_pulses[%0d]: got vld=%0d err=%0d expected %0d %0d", k, n_vld, n_err, exp_vld, exp_err);
         else n_pass++;
         n_checks++;
         if ({scan_code_o, break_o, ext_o, keycode_o} !== {m_code, m_brk_o, m_ext_o, m_key})
            $display("FAIL rand_outputs[%0d]: got %h/%b/%b key=%h expected %h/%b/%b key=%h",
                     k, scan_code_o, break_o, ext_o, keycode_o, m_code, m_brk_o, m_ext_o, m_key);
         else n_pass++;
`ifdef PS2_ERR_CNT_EN
         n_checks++;
         if (err_cnt_o !== m_errcnt[7:0]) $display("FAIL rand_err_cnt[%0d]: got %0d expected %0d", k, err_cnt_o, m_errcnt);
         else n_pass++;
`endif
      end
   endtask

   initial begin
      rstn = 1'b0;
      kclk = 1'b1;
      kdata = 1'b1;
      model_reset();
      test_reset();
      test_make();
      test_break();
      test_ext();
      test_parity();
      test_timeout();
      test_glitch();
      test_mid_reset();
`ifdef PS2_ERR_CNT_EN
      test_err_cnt();
`endif
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
